// File: rtl/fmul_wb_queue.sv
// fmul_wb_queue: writeback buffer behind the single-precision multiplier.
// Captures {tag, ovf, y} into a circular FIFO. Presents the head entry to the
// register-file write port. Maintains a sticky overflow flag and a saturating
// overflow event counter for the FPU status register.
//
// Optional feature macro: FMUL_WB_BYPASS_EN
//   When defined, an empty queue with a waiting consumer forwards the input
//   combinationally to the output in the same cycle, without storing it.
//   When undefined, there is no input-to-output combinational path.
//
// Handshake (both sides): a transfer happens at a rising edge where valid and
// ready are both high. Valid never waits for ready. in_ready depends only on
// registered occupancy, so a pop cannot make room for a push in the same cycle.
module fmul_wb_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_y,
  input  logic                     in_ovf,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_y,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_ovf,
  output logic                     out_zero,
  input  logic                     flush,
  input  logic                     flag_clr,
  output logic                     ovf_sticky,
  output logic [15:0]              ovf_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = DEPTH;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [15:0]   OVF_MAX  = 16'hFFFF;

  // Entry storage, one array per field
  logic [31:0]      y_q   [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic             ovf_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          sticky_q, sticky_d;
  logic [15:0]   ovf_cnt_q, ovf_cnt_d;

  logic head_valid;
  logic bypass;
  logic push_acc;
  logic do_store;
  logic do_pop;

  // Handshake decode: acceptance, storage write, head pop
  always_comb begin
    in_ready   = (count_q != CNT_FULL);
    head_valid = (count_q != '0);
`ifdef FMUL_WB_BYPASS_EN
    bypass     = (count_q == '0) && in_valid && out_ready;
`else
    bypass     = 1'b0;
`endif
    push_acc   = in_valid && in_ready;
    // A bypassed entry leaves immediately, so it is never written to storage.
    do_store   = push_acc && !bypass && !flush;
    do_pop     = head_valid && out_ready && !flush;
  end

  // Next pointer and occupancy; flush overrides any same-cycle push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_store) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_store && !do_pop)      count_d = count_q + CNT_ONE;
      else if (!do_store && do_pop) count_d = count_q - CNT_ONE;
    end
  end

  // Next sticky flag and counter; a same-cycle clear loses to the new event
  always_comb begin
    sticky_d  = sticky_q;
    ovf_cnt_d = ovf_cnt_q;
    if (flag_clr) begin
      sticky_d  = 1'b0;
      ovf_cnt_d = '0;
    end
    if (push_acc && in_ovf && !flush) begin
      sticky_d = 1'b1;
      if (ovf_cnt_d != OVF_MAX) ovf_cnt_d = ovf_cnt_d + 16'd1;
    end
  end

  // Pointer, occupancy and entry storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        y_q[i]   <= '0;
        tag_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_store) begin
        y_q[wr_ptr_q]   <= in_y;
        tag_q[wr_ptr_q] <= in_tag;
        ovf_q[wr_ptr_q] <= in_ovf;
      end
    end
  end

  // Overflow status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q  <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      sticky_q  <= sticky_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Output mux: stored head entry, or the live input when bypassing
  always_comb begin
    out_valid = head_valid;
    out_y     = y_q[rd_ptr_q];
    out_tag   = tag_q[rd_ptr_q];
    out_ovf   = ovf_q[rd_ptr_q];
    if (bypass) begin
      out_valid = 1'b1;
      out_y     = in_y;
      out_tag   = in_tag;
      out_ovf   = in_ovf;
    end
    // A zero exponent field is how the codebase recognises zero.
    out_zero = (out_y[30:23] == 8'd0);
  end

  assign ovf_sticky = sticky_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign count      = count_q;

endmodule
